// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch squash and memory-wait sequencing for the IF/ID, ID/EX and EX/MEM registers
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_we,
  input  logic             ex_load,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, MWAIT} state_t;
  state_t cur, nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic load_use;
  assign state = cur;
  assign load_use = ex_load & ex_we & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  always_comb begin
    {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
    {ifid_flush, idex_flush} = 2'b00;
    nxt = RUN;
    fcnt_nxt = fcnt;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      {ifid_flush, idex_flush} = 2'b11;
      fcnt_nxt = '0;
    end else if (mem_busy) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      nxt = (cur == FLUSH) ? FLUSH : MWAIT;
    end else if (cur == FLUSH) begin
      ifid_flush = 1'b1;
      nxt = (fcnt == FW'(1)) ? RUN : FLUSH;
      fcnt_nxt = fcnt - 1'b1;
    end else if (ex_branch_taken) begin
      // the instruction in ID is wrong-path, so the branch wins over load-use
      {ifid_flush, idex_flush} = 2'b11;
      nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      fcnt_nxt = FW'(FLUSH_CYCLES - 1);
    end else if (load_use && cur != LDSTALL) begin
      {pc_en, ifid_en} = 2'b00;
      idex_flush = 1'b1;
      nxt = LDSTALL;
    end
  end
  always_ff @(posedge clk) begin
    cur <= nxt;
    fcnt <= fcnt_nxt;
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= stall_count + CNT_W'(!pc_en && !(&stall_count));
      flush_count <= flush_count + CNT_W'(ifid_flush && !(&flush_count));
    end
  end
endmodule
